// File: rtl/lcd_nibble_receiver_if.sv
// 4-bit LCD write bus plus the receiver's byte/status outputs.
// The writer drives the LCD pins; the receiver drives everything else.
interface lcd_nibble_receiver_if;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [3:0] SF_D;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_rs;
  logic       busy;
  logic       err_pulse;
  logic       err_gap;
  logic       err_busy;

  modport master (
    output LCD_E, LCD_RS, LCD_RW, SF_D,
    input  byte_valid, byte_data, byte_rs, busy, err_pulse, err_gap, err_busy
  );
  modport slave (
    input  LCD_E, LCD_RS, LCD_RW, SF_D,
    output byte_valid, byte_data, byte_rs, busy, err_pulse, err_gap, err_busy
  );
endinterface

// File: rtl/lcd_nibble_receiver.sv
// LCD-side display model: pairs nibbles latched on LCD_E falls into bytes,
// models the post-byte busy window and flags protocol timing violations.
module lcd_nibble_receiver #(
  parameter int E_MIN_HIGH  = 12,
  parameter int GAP_MIN     = 50,
  parameter int GAP_TIMEOUT = 4000,
  parameter int BUSY_CYCLES = 2000
) (
  input logic clk,
  input logic reset,
  lcd_nibble_receiver_if.slave bus
);
  localparam int EW = $clog2(E_MIN_HIGH + 1);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam int BW = $clog2(BUSY_CYCLES + 1);
  localparam logic [EW-1:0] E_MIN_W   = EW'(E_MIN_HIGH);
  localparam logic [GW:0]   GAP_MIN_W = (GW+1)'(GAP_MIN);
  localparam logic [GW:0]   GAP_TO_W  = (GW+1)'(GAP_TIMEOUT);
  localparam logic [BW-1:0] BUSY_INIT = BW'(BUSY_CYCLES - 1);

  typedef enum logic [1:0] {WAIT_HI, WAIT_LO, BUSY} state_t;
  state_t state;

  logic          r_e, r_rs, r_rw;
  logic [3:0]    r_d;
  logic [EW-1:0] ehi_cnt;
  logic          p_fall, p_short, p_rs, p_rw;
  logic [3:0]    p_d;
  logic [3:0]    hi;
  logic          hi_rs;
  logic [GW-1:0] gap_cnt;
  logic [BW-1:0] busy_cnt;
  logic          byte_valid_q, byte_rs_q, busy_q;
  logic [7:0]    byte_data_q;
  logic          err_pulse_q, err_gap_q, err_busy_q;

  logic          fall, p_take;
  logic [GW:0]   elapsed;

  assign fall    = r_e & ~bus.LCD_E;
  assign p_take  = p_fall & ~p_rw;
  // cycles between the first nibble's fall and the fall being judged now
  assign elapsed = {1'b0, gap_cnt} + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_HI;
      r_e          <= 1'b0;
      r_rs         <= 1'b0;
      r_rw         <= 1'b0;
      r_d          <= '0;
      ehi_cnt      <= '0;
      p_fall       <= 1'b0;
      p_short      <= 1'b0;
      p_rs         <= 1'b0;
      p_rw         <= 1'b0;
      p_d          <= '0;
      hi           <= '0;
      hi_rs        <= 1'b0;
      gap_cnt      <= '0;
      busy_cnt     <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      byte_rs_q    <= 1'b0;
      busy_q       <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_gap_q    <= 1'b0;
      err_busy_q   <= 1'b0;
    end else begin
      r_e  <= bus.LCD_E;
      r_rs <= bus.LCD_RS;
      r_rw <= bus.LCD_RW;
      r_d  <= bus.SF_D;
      if (!bus.LCD_E)             ehi_cnt <= '0;
      else if (ehi_cnt != E_MIN_W) ehi_cnt <= ehi_cnt + 1'b1;

      // the fall and the last E-high sample are judged one cycle later
      p_fall  <= fall;
      p_short <= (ehi_cnt < E_MIN_W);
      p_d     <= r_d;
      p_rs    <= r_rs;
      p_rw    <= r_rw;

      byte_valid_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_gap_q    <= 1'b0;
      err_busy_q   <= 1'b0;

      case (state)
        WAIT_HI: begin
          if (p_take) begin
            if (p_short) err_pulse_q <= 1'b1;
            else begin
              hi      <= p_d;
              hi_rs   <= p_rs;
              gap_cnt <= '0;
              state   <= WAIT_LO;
            end
          end
        end
        WAIT_LO: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (p_take) begin
            if (p_short) err_pulse_q <= 1'b1;
            else if (elapsed < GAP_MIN_W || p_rs != hi_rs) begin
              err_gap_q <= 1'b1;
              state     <= WAIT_HI;
            end else begin
              byte_data_q  <= {hi, p_d};
              byte_rs_q    <= p_rs;
              byte_valid_q <= 1'b1;
              busy_q       <= 1'b1;
              busy_cnt     <= BUSY_INIT;
              state        <= BUSY;
            end
          end else if (elapsed >= GAP_TO_W) begin
            // >= so a short pulse landing on the timeout cycle only defers it
            err_gap_q <= 1'b1;
            state     <= WAIT_HI;
          end
        end
        BUSY: begin
          if (p_take) begin
            if (p_short) err_pulse_q <= 1'b1;
            else         err_busy_q  <= 1'b1;
          end
          if (busy_cnt == '0) begin
            busy_q <= 1'b0;
            state  <= WAIT_HI;
          end else begin
            busy_cnt <= busy_cnt - 1'b1;
          end
        end
        default: state <= WAIT_HI;
      endcase
    end
  end

  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data  = byte_data_q;
  assign bus.byte_rs    = byte_rs_q;
  assign bus.busy       = busy_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_gap    = err_gap_q;
  assign bus.err_busy   = err_busy_q;
endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Directed bench for lcd_nibble_receiver: timestamp-based reference model
// compared every cycle, plus literal byte/flag/busy-length expectations.
module tb_lcd_nibble_receiver;
  localparam int E_MIN_HIGH  = 12;
  localparam int GAP_MIN     = 50;
  localparam int GAP_TIMEOUT = 4000;
  localparam int BUSY_CYCLES = 2000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lcd_nibble_receiver_if bus();

  lcd_nibble_receiver #(
    .E_MIN_HIGH(E_MIN_HIGH), .GAP_MIN(GAP_MIN),
    .GAP_TIMEOUT(GAP_TIMEOUT), .BUSY_CYCLES(BUSY_CYCLES)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: edge index of each event, derived from sampled inputs
  int cyc = 0;
  bit model_on = 0;
  bit m_prev_e;
  int m_hicnt;
  logic [3:0] m_d;
  bit m_rs, m_rw;
  bit pend, pd_short, pd_rs, pd_rw;
  logic [3:0] pd_d;
  bit have_hi, hi_rs;
  logic [3:0] hi;
  int t_hi, bstart;
  bit e_bv, e_brs, e_busy, e_ep, e_eg, e_eb;
  logic [7:0] e_bd;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      model_on = 1; m_prev_e = 0; m_hicnt = 0; m_d = 0; m_rs = 0; m_rw = 0;
      pend = 0; have_hi = 0; bstart = -100000;
      e_bv = 0; e_bd = 0; e_brs = 0; e_busy = 0; e_ep = 0; e_eg = 0; e_eb = 0;
    end else begin
      e_bv = 0; e_ep = 0; e_eg = 0; e_eb = 0;
      if (pend && !pd_rw) begin
        if (pd_short) e_ep = 1;
        else if (cyc >= bstart + 1 && cyc <= bstart + BUSY_CYCLES) e_eb = 1;
        else if (have_hi) begin
          if (cyc - t_hi < GAP_MIN || pd_rs != hi_rs) e_eg = 1;
          else begin e_bv = 1; e_bd = {hi, pd_d}; e_brs = pd_rs; bstart = cyc; end
          have_hi = 0;
        end else begin
          have_hi = 1; hi = pd_d; hi_rs = pd_rs; t_hi = cyc;
        end
      end else if (have_hi && cyc - t_hi >= GAP_TIMEOUT) begin
        e_eg = 1; have_hi = 0;
      end
      e_busy = (cyc >= bstart && cyc < bstart + BUSY_CYCLES);
      pend = m_prev_e && !bus.LCD_E;
      pd_short = (m_hicnt < E_MIN_HIGH);
      pd_d = m_d; pd_rs = m_rs; pd_rw = m_rw;
      m_hicnt = !bus.LCD_E ? 0 : (m_hicnt < E_MIN_HIGH ? m_hicnt + 1 : m_hicnt);
      m_prev_e = bus.LCD_E; m_d = bus.SF_D; m_rs = bus.LCD_RS; m_rw = bus.LCD_RW;
    end
  end

  // per-cycle compare plus event statistics for the literal checks
  int n_bv = 0, n_ep = 0, n_eg = 0, n_eb = 0;
  int busy_run = 0, last_busy_len = 0;
  logic [7:0] last_bd = 0;
  bit last_brs = 0;

  always @(negedge clk) begin
    if (model_on) begin
      chk($sformatf("outputs@%0d", cyc),
          int'({bus.byte_valid, bus.byte_data, bus.byte_rs, bus.busy,
                bus.err_pulse, bus.err_gap, bus.err_busy}),
          int'({e_bv, e_bd, e_brs, e_busy, e_ep, e_eg, e_eb}));
    end
    if (bus.byte_valid === 1'b1) begin n_bv++; last_bd = bus.byte_data; last_brs = bus.byte_rs; end
    if (bus.err_pulse === 1'b1) n_ep++;
    if (bus.err_gap === 1'b1) n_eg++;
    if (bus.err_busy === 1'b1) n_eb++;
    if (bus.busy === 1'b1) busy_run++;
    else if (busy_run > 0) begin last_busy_len = busy_run; busy_run = 0; end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk) #1;
  endtask

  task automatic nib(input logic [3:0] d, input bit rs, input int hi_cyc, input bit rw);
    bus.SF_D = d; bus.LCD_RS = rs; bus.LCD_RW = rw; bus.LCD_E = 1'b1;
    idle(hi_cyc);
    bus.LCD_E = 1'b0;
  endtask

  // gap = cycles between the two E falls
  task automatic send_byte(input logic [7:0] b, input bit rs, input int gap);
    nib(b[7:4], rs, E_MIN_HIGH, 0);
    idle(gap - E_MIN_HIGH);
    nib(b[3:0], rs, E_MIN_HIGH, 0);
  endtask

  task automatic wait_not_busy(input string name);
    int k;
    k = 0;
    while (bus.busy === 1'b1 && k < 3000) begin idle(1); k++; end
    chk(name, int'(bus.busy === 1'b1), 0);
  endtask

  int b0, p0, g0, u0;

  initial begin
    bus.LCD_E = 0; bus.LCD_RS = 0; bus.LCD_RW = 0; bus.SF_D = 0;
    idle(3);
    chk("reset_outs", int'({bus.byte_valid, bus.byte_data, bus.busy, bus.err_gap}), 0);
    reset = 0;
    idle(5);

    // 1: 0x38 command
    b0 = n_bv;
    send_byte(8'h38, 0, 50);
    idle(2100);
    chk("t1_count", n_bv - b0, 1);
    chk("t1_byte", last_bd, 8'h38);
    chk("t1_rs", last_brs, 0);
    chk("t1_busy_len", last_busy_len, BUSY_CYCLES);

    // 2: data 0x41 then back-to-back 0x42 right after busy falls
    b0 = n_bv;
    send_byte(8'h41, 1, 50);
    idle(3);
    chk("t2_byte", last_bd, 8'h41);
    chk("t2_rs", last_brs, 1);
    wait_not_busy("t2_busy_timeout");
    send_byte(8'h42, 1, 50);
    idle(3);
    chk("t2_back2back", n_bv - b0, 2);
    chk("t2_byte2", last_bd, 8'h42);
    wait_not_busy("t2_busy_timeout2");

    // 3: short pulse then nominal 0x28
    p0 = n_ep; b0 = n_bv;
    nib(4'h2, 0, 5, 0);
    idle(20);
    chk("t3_err_pulse", n_ep - p0, 1);
    send_byte(8'h28, 0, 50);
    idle(3);
    chk("t3_byte", last_bd, 8'h28);
    chk("t3_count", n_bv - b0, 1);
    wait_not_busy("t3_busy_timeout");

    // 4: gap too short, then abandoned lone nibble
    g0 = n_eg; b0 = n_bv;
    send_byte(8'h15, 0, 20);
    idle(60);
    chk("t4_short_gap", n_eg - g0, 1);
    nib(4'h7, 0, E_MIN_HIGH, 0);
    idle(GAP_TIMEOUT + 20);
    chk("t4_timeout", n_eg - g0, 2);
    chk("t4_no_byte", n_bv - b0, 0);

    // 5: nibble during busy, then RS mismatch
    u0 = n_eb; g0 = n_eg; b0 = n_bv;
    send_byte(8'h55, 0, 50);
    idle(1000);
    nib(4'h9, 0, E_MIN_HIGH, 0);
    idle(5);
    chk("t5_err_busy", n_eb - u0, 1);
    wait_not_busy("t5_busy_timeout");
    idle(2);
    chk("t5_busy_len", last_busy_len, BUSY_CYCLES);
    nib(4'h1, 0, E_MIN_HIGH, 0);
    idle(GAP_MIN - E_MIN_HIGH);
    nib(4'h2, 1, E_MIN_HIGH, 0);
    idle(5);
    chk("t5_rs_mismatch", n_eg - g0, 1);
    chk("t5_bytes", n_bv - b0, 1);

    // 6: reset mid-byte, then 0x0C with read cycles mixed in
    nib(4'h3, 0, E_MIN_HIGH, 0);
    idle(10);
    reset = 1;
    idle(2);
    reset = 0;
    idle(1);
    chk("t6_reset_data", int'(bus.byte_data), 0);
    chk("t6_reset_busy", int'(bus.busy), 0);
    p0 = n_ep; g0 = n_eg; u0 = n_eb; b0 = n_bv;
    nib(4'hF, 0, 3, 1);
    idle(10);
    nib(4'h0, 0, E_MIN_HIGH, 0);
    idle(5);
    nib(4'hF, 1, E_MIN_HIGH, 1);
    idle(21);
    nib(4'hC, 0, E_MIN_HIGH, 0);
    idle(5);
    chk("t6_byte", last_bd, 8'h0C);
    chk("t6_count", n_bv - b0, 1);
    chk("t6_no_flags", (n_ep - p0) + (n_eg - g0) + (n_eb - u0), 0);
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
